// File: rtl/mmio_report_control_pkg.sv
// mmio_report_control_pkg: report FSM states, MMIO address map and statistics layout.
package mmio_report_control_pkg;

    typedef enum logic [1:0] {
        REPORT_IDLE,
        REPORT_PENDING,
        REPORT_ACK,
        REPORT_WAIT_CLEAR
    } report_state;

    // Addresses are in 32-bit word units; every register is 64 bits, so entries sit on even addresses.
    localparam logic [0:23] REPORT_STATUS_ADDR     = 24'h000040;
    localparam logic [0:23] REPORT_STATS_BASE_ADDR = 24'h000042;
    localparam logic [0:23] REPORT_COUNT_ADDR      = 24'h000060;

    typedef struct packed {
        logic [0:63] total_responses;
        logic [0:63] read_responses;
        logic [0:63] write_responses;
        logic [0:63] error_responses;
        logic [0:63] read_bytes;
        logic [0:63] write_bytes;
        logic [0:63] busy_cycles;
        logic [0:63] stall_cycles;
    } ResponseStatistcsInterface;

endpackage

// File: rtl/mmio_report_decode.sv
// mmio_report_decode: registered MMIO read decode for the report registers.
// The count register is mapped only when REPORT_COUNTER_EN is defined.
module mmio_report_decode
    import mmio_report_control_pkg::*;
#(
    parameter int STAT_WORDS = 8
) (
    input  logic                      clock,
    input  logic                      rstn,
    input  logic                      rd_valid,
    input  logic [0:23]               rd_addr,
    input  logic [0:63]               status,
    input  logic [0:STAT_WORDS*64-1]  stats,
`ifdef REPORT_COUNTER_EN
    input  logic [63:0]               count,
`endif
    output logic                      rd_data_valid,
    output logic [0:63]               rd_data,
    output logic                      status_read_hit
);

    logic        hit;
    logic [0:63] data;

    // The status hit is combinational so the FSM can acknowledge on the same edge the read is registered.
    always_comb begin
        status_read_hit = rd_valid && rd_addr == REPORT_STATUS_ADDR;
        hit = status_read_hit;
        data = status_read_hit ? status : '0;
        for (int i = 0; i < STAT_WORDS; i++)
            if (rd_valid && rd_addr == REPORT_STATS_BASE_ADDR + 24'(2 * i)) begin
                hit = 1'b1;
                data = stats[i*64 +: 64];
            end
`ifdef REPORT_COUNTER_EN
        if (rd_valid && rd_addr == REPORT_COUNT_ADDR) begin
            hit = 1'b1;
            data = count;
        end
`endif
    end

    always_ff @(posedge clock or negedge rstn)
        if (!rstn) begin
            rd_data_valid <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_data_valid <= hit;
            rd_data <= data;
        end

endmodule

// File: rtl/mmio_report_control.sv
// mmio_report_control: latches the done controller's report and serves it over MMIO reads.
// Define REPORT_COUNTER_EN to add a 64-bit acknowledged-report counter at REPORT_COUNT_ADDR.
module mmio_report_control
    import mmio_report_control_pkg::*;
#(
    parameter int STAT_WORDS = 8
) (
    input  logic                      clock,
    input  logic                      rstn,
    input  logic                      enabled_in,
    input  logic [0:63]               report_algorithm_status,
    input  ResponseStatistcsInterface report_response_statistics,
    input  logic                      mmio_rd_valid,
    input  logic [0:23]               mmio_rd_addr,
    output logic                      mmio_rd_data_valid,
    output logic [0:63]               mmio_rd_data,
    output logic                      report_algorithm_status_ack,
    output logic                      report_pending
);

    logic                      enabled;
    report_state               state, next_state;
    logic [0:63]               status_q;
    ResponseStatistcsInterface stats_q;
    logic                      status_read_hit;
    logic                      capture;

    assign capture = enabled && state == REPORT_IDLE && |report_algorithm_status;
    assign report_pending = state == REPORT_PENDING;
    assign report_algorithm_status_ack = enabled && state == REPORT_ACK;

    always_ff @(posedge clock or negedge rstn)
        if (!rstn) enabled <= 1'b0;
        else enabled <= enabled_in;

    always_ff @(posedge clock or negedge rstn)
        if (!rstn) state <= REPORT_IDLE;
        else state <= next_state;

    // WAIT_CLEAR holds until the done controller drops its status, so one report is never captured twice.
    always_comb begin
        next_state = state;
        if (enabled)
            case (state)
                REPORT_IDLE:    next_state = |report_algorithm_status ? REPORT_PENDING : REPORT_IDLE;
                REPORT_PENDING: next_state = status_read_hit ? REPORT_ACK : REPORT_PENDING;
                REPORT_ACK:     next_state = REPORT_WAIT_CLEAR;
                default:        next_state = |report_algorithm_status ? REPORT_WAIT_CLEAR : REPORT_IDLE;
            endcase
    end

    always_ff @(posedge clock or negedge rstn)
        if (!rstn) begin
            status_q <= '0;
            stats_q <= '0;
        end else if (capture) begin
            status_q <= report_algorithm_status;
            stats_q <= report_response_statistics;
        end

`ifdef REPORT_COUNTER_EN
    logic [63:0] report_count;

    always_ff @(posedge clock or negedge rstn)
        if (!rstn) report_count <= '0;
        else if (report_algorithm_status_ack) report_count <= report_count + 64'd1;
`endif

    mmio_report_decode #(
        .STAT_WORDS(STAT_WORDS)
    ) u_decode (
        .clock          (clock),
        .rstn           (rstn),
        .rd_valid       (mmio_rd_valid),
        .rd_addr        (mmio_rd_addr),
        .status         (state == REPORT_IDLE ? 64'd0 : status_q),
        .stats          (stats_q),
`ifdef REPORT_COUNTER_EN
        .count          (report_count),
`endif
        .rd_data_valid  (mmio_rd_data_valid),
        .rd_data        (mmio_rd_data),
        .status_read_hit(status_read_hit)
    );

endmodule

// File: tb/tb_mmio_report_control.sv
// tb_mmio_report_control: scoreboard bench for the report FSM and MMIO read decode.
module tb_mmio_report_control;
    import mmio_report_control_pkg::*;

    logic                      clock;
    logic                      rstn;
    logic                      enabled_in;
    logic [0:63]               report_algorithm_status;
    ResponseStatistcsInterface report_response_statistics;
    logic                      mmio_rd_valid;
    logic [0:23]               mmio_rd_addr;
    logic                      mmio_rd_data_valid;
    logic [0:63]               mmio_rd_data;
    logic                      report_algorithm_status_ack;
    logic                      report_pending;

    typedef struct {
        logic        v;
        logic [0:63] d;
    } rsp_t;

    rsp_t        exp_q[$];
    rsp_t        e;
    int          tests = 0;
    int          fails = 0;
    int          ack_pulses = 0;
    int          a0;
    logic [0:511] sv;

    mmio_report_control #(.STAT_WORDS(8)) dut (
        .clock                      (clock),
        .rstn                       (rstn),
        .enabled_in                 (enabled_in),
        .report_algorithm_status    (report_algorithm_status),
        .report_response_statistics (report_response_statistics),
        .mmio_rd_valid              (mmio_rd_valid),
        .mmio_rd_addr               (mmio_rd_addr),
        .mmio_rd_data_valid         (mmio_rd_data_valid),
        .mmio_rd_data               (mmio_rd_data),
        .report_algorithm_status_ack(report_algorithm_status_ack),
        .report_pending             (report_pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock)
        if (report_algorithm_status_ack) ack_pulses <= ack_pulses + 1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [0:23] a, input logic v, input logic [0:63] d);
        exp_q.push_back('{v, d});
        mmio_rd_valid = 1'b1;
        mmio_rd_addr = a;
        tick();
        mmio_rd_valid = 1'b0;
    endtask

    task automatic ack_cycle(input logic [0:63] s);
        report_algorithm_status = s;
        tick();
        mmio_rd_valid = 1'b1;
        mmio_rd_addr = REPORT_STATUS_ADDR;
        tick();
        mmio_rd_valid = 1'b0;
        tick();
        report_algorithm_status = '0;
        tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        enabled_in = 1'b0;
        report_algorithm_status = '0;
        report_response_statistics = '0;
        mmio_rd_valid = 1'b0;
        mmio_rd_addr = '0;
        tick();
        tick();
        tests++;
        if ({mmio_rd_data_valid, mmio_rd_data, report_algorithm_status_ack, report_pending} !== 67'd0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%0b data=%h ack=%0b pending=%0b, expected all 0",
                     mmio_rd_data_valid, mmio_rd_data, report_algorithm_status_ack, report_pending);
        end
        rstn = 1'b1;
        enabled_in = 1'b1;
        tick();
    endtask

    task automatic test_idle_read();
        rd(REPORT_STATUS_ADDR, 1'b1, 64'h0);
        e = exp_q.pop_front(); tests++;
        if (mmio_rd_data_valid !== e.v || mmio_rd_data !== e.d || report_algorithm_status_ack !== 1'b0) begin
            fails++;
            $display("FAIL idle_status: got valid=%0b data=%h ack=%0b, expected valid=%0b data=%h ack=0",
                     mmio_rd_data_valid, mmio_rd_data, report_algorithm_status_ack, e.v, e.d);
        end
        rd(24'h000010, 1'b0, 64'h0);
        e = exp_q.pop_front(); tests++;
        if (mmio_rd_data_valid !== e.v || mmio_rd_data !== e.d) begin
            fails++;
            $display("FAIL idle_unmapped: got valid=%0b data=%h, expected valid=%0b data=%h",
                     mmio_rd_data_valid, mmio_rd_data, e.v, e.d);
        end
        rd(REPORT_STATUS_ADDR + 24'd1, 1'b0, 64'h0);
        e = exp_q.pop_front(); tests++;
        if (mmio_rd_data_valid !== e.v || mmio_rd_data !== e.d) begin
            fails++;
            $display("FAIL idle_odd_addr: got valid=%0b data=%h, expected valid=%0b data=%h",
                     mmio_rd_data_valid, mmio_rd_data, e.v, e.d);
        end
    endtask

    task automatic test_basic();
        sv = '0;
        sv[0:63] = 64'hA5;
        sv[192:255] = 64'h3333;
        sv[448:511] = 64'h7777_0000_0000_0007;
        report_response_statistics = sv;
        report_algorithm_status = 64'h1;
        tick();
        tests++;
        if (report_pending !== 1'b1) begin
            fails++;
            $display("FAIL basic_capture: got pending=%0b, expected 1", report_pending);
        end
        rd(REPORT_STATS_BASE_ADDR + 24'd6, 1'b1, 64'h3333);
        e = exp_q.pop_front(); tests++;
        if (mmio_rd_data_valid !== e.v || mmio_rd_data !== e.d || report_algorithm_status_ack !== 1'b0 || report_pending !== 1'b1) begin
            fails++;
            $display("FAIL stats_word3: got valid=%0b data=%h ack=%0b pending=%0b, expected valid=%0b data=%h ack=0 pending=1",
                     mmio_rd_data_valid, mmio_rd_data, report_algorithm_status_ack, report_pending, e.v, e.d);
        end
        rd(REPORT_STATS_BASE_ADDR + 24'd14, 1'b1, 64'h7777_0000_0000_0007);
        e = exp_q.pop_front(); tests++;
        if (mmio_rd_data_valid !== e.v || mmio_rd_data !== e.d) begin
            fails++;
            $display("FAIL stats_word7: got valid=%0b data=%h, expected valid=%0b data=%h",
                     mmio_rd_data_valid, mmio_rd_data, e.v, e.d);
        end
        rd(REPORT_STATUS_ADDR, 1'b1, 64'h1);
        e = exp_q.pop_front(); tests++;
        if (mmio_rd_data_valid !== e.v || mmio_rd_data !== e.d || report_algorithm_status_ack !== 1'b1 || report_pending !== 1'b0) begin
            fails++;
            $display("FAIL basic_status_ack: got valid=%0b data=%h ack=%0b pending=%0b, expected valid=%0b data=%h ack=1 pending=0",
                     mmio_rd_data_valid, mmio_rd_data, report_algorithm_status_ack, report_pending, e.v, e.d);
        end
        tick();
        tests++;
        if (report_algorithm_status_ack !== 1'b0) begin
            fails++;
            $display("FAIL basic_ack_single: got ack=%0b, expected 0", report_algorithm_status_ack);
        end
        rd(REPORT_STATS_BASE_ADDR, 1'b1, 64'hA5);
        e = exp_q.pop_front(); tests++;
        if (mmio_rd_data_valid !== e.v || mmio_rd_data !== e.d) begin
            fails++;
            $display("FAIL stats_retained: got valid=%0b data=%h, expected valid=%0b data=%h",
                     mmio_rd_data_valid, mmio_rd_data, e.v, e.d);
        end
    endtask

    task automatic test_hold_after_ack();
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (report_pending !== 1'b0 || report_algorithm_status_ack !== 1'b0) begin
                fails++;
                $display("FAIL hold_no_recapture: cycle %0d got pending=%0b ack=%0b, expected 0/0",
                         i, report_pending, report_algorithm_status_ack);
            end
        end
        rd(REPORT_STATUS_ADDR, 1'b1, 64'h1);
        e = exp_q.pop_front(); tests++;
        if (mmio_rd_data_valid !== e.v || mmio_rd_data !== e.d || report_algorithm_status_ack !== 1'b0) begin
            fails++;
            $display("FAIL hold_status_latched: got valid=%0b data=%h ack=%0b, expected valid=%0b data=%h ack=0",
                     mmio_rd_data_valid, mmio_rd_data, report_algorithm_status_ack, e.v, e.d);
        end
        report_algorithm_status = '0;
        tick();
        rd(REPORT_STATUS_ADDR, 1'b1, 64'h0);
        e = exp_q.pop_front(); tests++;
        if (mmio_rd_data_valid !== e.v || mmio_rd_data !== e.d) begin
            fails++;
            $display("FAIL rearm_idle: got valid=%0b data=%h, expected valid=%0b data=%h",
                     mmio_rd_data_valid, mmio_rd_data, e.v, e.d);
        end
        report_algorithm_status = 64'h2;
        tick();
        rd(REPORT_STATUS_ADDR, 1'b1, 64'h2);
        e = exp_q.pop_front(); tests++;
        if (mmio_rd_data_valid !== e.v || mmio_rd_data !== e.d || report_algorithm_status_ack !== 1'b1) begin
            fails++;
            $display("FAIL fresh_capture: got valid=%0b data=%h ack=%0b, expected valid=%0b data=%h ack=1",
                     mmio_rd_data_valid, mmio_rd_data, report_algorithm_status_ack, e.v, e.d);
        end
        report_algorithm_status = '0;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        report_algorithm_status = 64'h7;
        tick();
        a0 = ack_pulses;
        mmio_rd_valid = 1'b1;
        mmio_rd_addr = REPORT_STATUS_ADDR;
        exp_q.push_back('{1'b1, 64'h7});
        tick();
        e = exp_q.pop_front(); tests++;
        if (mmio_rd_data_valid !== e.v || mmio_rd_data !== e.d) begin
            fails++;
            $display("FAIL b2b_first: got valid=%0b data=%h, expected valid=%0b data=%h",
                     mmio_rd_data_valid, mmio_rd_data, e.v, e.d);
        end
        exp_q.push_back('{1'b1, 64'h7});
        tick();
        mmio_rd_valid = 1'b0;
        e = exp_q.pop_front(); tests++;
        if (mmio_rd_data_valid !== e.v || mmio_rd_data !== e.d) begin
            fails++;
            $display("FAIL b2b_second: got valid=%0b data=%h, expected valid=%0b data=%h",
                     mmio_rd_data_valid, mmio_rd_data, e.v, e.d);
        end
        tick();
        tick();
        tests++;
        if (ack_pulses - a0 !== 1) begin
            fails++;
            $display("FAIL b2b_one_ack: got %0d ack pulses, expected 1", ack_pulses - a0);
        end
        report_algorithm_status = '0;
        tick();
    endtask

    task automatic test_simultaneous();
        report_algorithm_status = 64'h3;
        rd(REPORT_STATUS_ADDR, 1'b1, 64'h0);
        e = exp_q.pop_front(); tests++;
        if (mmio_rd_data_valid !== e.v || mmio_rd_data !== e.d || report_pending !== 1'b1) begin
            fails++;
            $display("FAIL capture_read_same_cycle: got valid=%0b data=%h pending=%0b, expected valid=%0b data=%h pending=1",
                     mmio_rd_data_valid, mmio_rd_data, report_pending, e.v, e.d);
        end
        tick();
        tests++;
        if (report_algorithm_status_ack !== 1'b0 || report_pending !== 1'b1) begin
            fails++;
            $display("FAIL capture_read_no_ack: got ack=%0b pending=%0b, expected 0/1",
                     report_algorithm_status_ack, report_pending);
        end
        rd(REPORT_STATUS_ADDR, 1'b1, 64'h3);
        e = exp_q.pop_front(); tests++;
        if (mmio_rd_data_valid !== e.v || mmio_rd_data !== e.d || report_algorithm_status_ack !== 1'b1) begin
            fails++;
            $display("FAIL capture_read_later_ack: got valid=%0b data=%h ack=%0b, expected valid=%0b data=%h ack=1",
                     mmio_rd_data_valid, mmio_rd_data, report_algorithm_status_ack, e.v, e.d);
        end
        report_algorithm_status = '0;
        tick();
        tick();
    endtask

    task automatic test_enable();
        report_algorithm_status = 64'h4;
        tick();
        enabled_in = 1'b0;
        tick();
        rd(REPORT_STATUS_ADDR, 1'b1, 64'h4);
        e = exp_q.pop_front(); tests++;
        if (mmio_rd_data_valid !== e.v || mmio_rd_data !== e.d || report_algorithm_status_ack !== 1'b0 || report_pending !== 1'b1) begin
            fails++;
            $display("FAIL disabled_read: got valid=%0b data=%h ack=%0b pending=%0b, expected valid=%0b data=%h ack=0 pending=1",
                     mmio_rd_data_valid, mmio_rd_data, report_algorithm_status_ack, report_pending, e.v, e.d);
        end
        tick();
        tests++;
        if (report_algorithm_status_ack !== 1'b0 || report_pending !== 1'b1) begin
            fails++;
            $display("FAIL disabled_hold: got ack=%0b pending=%0b, expected 0/1", report_algorithm_status_ack, report_pending);
        end
        enabled_in = 1'b1;
        tick();
        rd(REPORT_STATUS_ADDR, 1'b1, 64'h4);
        e = exp_q.pop_front(); tests++;
        if (mmio_rd_data_valid !== e.v || mmio_rd_data !== e.d || report_algorithm_status_ack !== 1'b1) begin
            fails++;
            $display("FAIL reenabled_ack: got valid=%0b data=%h ack=%0b, expected valid=%0b data=%h ack=1",
                     mmio_rd_data_valid, mmio_rd_data, report_algorithm_status_ack, e.v, e.d);
        end
        report_algorithm_status = '0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        report_algorithm_status = 64'h5;
        tick();
        rd(REPORT_STATS_BASE_ADDR, 1'b1, 64'hA5);
        e = exp_q.pop_front(); tests++;
        if (mmio_rd_data_valid !== e.v || mmio_rd_data !== e.d || report_pending !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_read: got valid=%0b data=%h pending=%0b, expected valid=%0b data=%h pending=1",
                     mmio_rd_data_valid, mmio_rd_data, report_pending, e.v, e.d);
        end
        #2 rstn = 1'b0;
        #1;
        tests++;
        if ({mmio_rd_data_valid, mmio_rd_data, report_algorithm_status_ack, report_pending} !== 67'd0) begin
            fails++;
            $display("FAIL async_reset: got valid=%0b data=%h ack=%0b pending=%0b, expected all 0",
                     mmio_rd_data_valid, mmio_rd_data, report_algorithm_status_ack, report_pending);
        end
        report_algorithm_status = '0;
        tick();
        rstn = 1'b1;
        tick();
        rd(REPORT_STATS_BASE_ADDR, 1'b1, 64'h0);
        e = exp_q.pop_front(); tests++;
        if (mmio_rd_data_valid !== e.v || mmio_rd_data !== e.d) begin
            fails++;
            $display("FAIL reset_clears_stats: got valid=%0b data=%h, expected valid=%0b data=%h",
                     mmio_rd_data_valid, mmio_rd_data, e.v, e.d);
        end
    endtask

    task automatic test_counter();
        a0 = ack_pulses;
        ack_cycle(64'h8);
        ack_cycle(64'h9);
        ack_cycle(64'hA);
        tests++;
        if (ack_pulses - a0 !== 3) begin
            fails++;
            $display("FAIL counter_acks: got %0d ack pulses, expected 3", ack_pulses - a0);
        end
`ifdef REPORT_COUNTER_EN
        rd(REPORT_COUNT_ADDR, 1'b1, 64'd3);
`else
        rd(REPORT_COUNT_ADDR, 1'b0, 64'd0);
`endif
        e = exp_q.pop_front(); tests++;
        if (mmio_rd_data_valid !== e.v || mmio_rd_data !== e.d) begin
            fails++;
            $display("FAIL counter_read: got valid=%0b data=%h, expected valid=%0b data=%h",
                     mmio_rd_data_valid, mmio_rd_data, e.v, e.d);
        end
    endtask

    initial begin
        test_reset();
        test_idle_read();
        test_basic();
        test_hold_after_ack();
        test_back_to_back();
        test_simultaneous();
        test_enable();
        test_reset_mid();
        test_counter();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
